// File: rtl/branch_predict_unit.sv
// Branch resolution and prediction unit. A direct-mapped table with 2-bit counters
// predicts at fetch, and the table is updated when the branch resolves in EX.
module branch_predict_unit #(
    parameter int ENTRY_BITS = 6,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           PCF,
    output logic                  PredictedF,
    output logic [31:0]           PredictedTargetF,
    input  logic [2:0]            BranchTypeE,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    input  logic [31:0]           PCE,
    input  logic [31:0]           BrTargetE,
    input  logic                  PredictedE,
    input  logic [31:0]           PredictedTargetE,
    input  logic                  StallE,
    input  logic                  CntClear,
    output logic                  BranchE,
    output logic                  MispredictE,
    output logic [31:0]           CorrectPCE,
    output logic [CNT_WIDTH-1:0]  BranchCount,
    output logic [CNT_WIDTH-1:0]  MissCount
);

    localparam int ENTRIES = 1 << ENTRY_BITS;
    localparam int TAG_W   = 32 - ENTRY_BITS - 2;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGE  = 3'd5,
        BR_BGEU = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [CNT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic [ENTRY_BITS-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]      tag_f, tag_e;
    logic                  hit_f, hit_e;
    logic                  valid_br;
    logic [1:0]            ctr_d;
    logic                  unused_pc_bits;

    assign idx_f = PCF[ENTRY_BITS+1:2];
    assign tag_f = PCF[31:ENTRY_BITS+2];
    assign idx_e = PCE[ENTRY_BITS+1:2];
    assign tag_e = PCE[31:ENTRY_BITS+2];
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0]};

    // Lookup reads registered state only, so an update in this cycle is seen next cycle.
    assign hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign PredictedF       = hit_f && ctr_q[idx_f][1];
    assign PredictedTargetF = hit_f ? target_q[idx_f] : PCF + 32'd4;

    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        BranchE = 1'b0;
        case (br_type_e'(BranchTypeE))
            BR_BEQ:  BranchE = (Operand1 == Operand2);
            BR_BNE:  BranchE = (Operand1 != Operand2);
            BR_BLT:  BranchE = ($signed(Operand1) <  $signed(Operand2));
            BR_BLTU: BranchE = (Operand1 <  Operand2);
            BR_BGE:  BranchE = ($signed(Operand1) >= $signed(Operand2));
            BR_BGEU: BranchE = (Operand1 >= Operand2);
            default: BranchE = 1'b0;
        endcase
    end

    assign valid_br    = (BranchTypeE != BR_NONE) && (BranchTypeE != BR_RSVD) && !StallE;
    assign MispredictE = valid_br && ((BranchE != PredictedE) ||
                         (BranchE && PredictedE && (BrTargetE != PredictedTargetE)));
    assign CorrectPCE  = BranchE ? BrTargetE : PCE + 32'd4;

    always_comb begin
        ctr_d = ctr_q[idx_e];
        if (BranchE && ctr_q[idx_e] != 2'b11) begin
            ctr_d = ctr_q[idx_e] + 2'd1;
        end else if (!BranchE && ctr_q[idx_e] != 2'b00) begin
            ctr_d = ctr_q[idx_e] - 2'd1;
        end
    end

    // NOTE: the table is reset entry by entry because a freshly reset unit must never hit;
    // that rules out a RAM macro without reset and keeps the arrays as flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (valid_br) begin
            if (hit_e) begin
                ctr_q[idx_e] <= ctr_d;
                if (BranchE) begin
                    target_q[idx_e] <= BrTargetE;
                end
            end else if (BranchE) begin
                valid_q[idx_e]  <= 1'b1;
                tag_q[idx_e]    <= tag_e;
                target_q[idx_e] <= BrTargetE;
                ctr_q[idx_e]    <= 2'b10;
            end
        end
    end

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (CntClear) begin
            branch_cnt_d = '0;
            miss_cnt_d   = '0;
        end else if (valid_br) begin
            if (branch_cnt_q != '1) begin
                branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            end
            if (MispredictE && miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign BranchCount = branch_cnt_q;
    assign MissCount   = miss_cnt_q;

endmodule
